// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and helpers for the instruction memory loader.
//   state_e            framing FSM states
//   DEFAULT_SYNC_BYTE  frame start marker
//   bytes_per_word()   WB = XLEN/8
//   addr_width()       ADDR_W = clog2(DEPTH)
//   byte_idx_width()   width of the in-word byte counter
// No ports (package).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int bytes_per_word(input int xlen);
    return xlen / 8;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int byte_idx_width(input int wb);
    return (wb > 1) ? $clog2(wb) : 1;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// DEPTH x XLEN instruction array, one synchronous write port and one
// asynchronous read port. The array is named mem so older benches can still
// reach it hierarchically.
// Ports:
//   clk    in  1       write clock, rising edge
//   we     in  1       write enable
//   waddr  in  ADDR_W  write word address
//   wdata  in  XLEN    write data
//   raddr  in  ADDR_W  read word address
//   rdata  out XLEN    read data (combinational; old word on same-cycle write)
// -----------------------------------------------------------------------------
module imem_ram #(
  parameter int DEPTH  = 256,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // NOTE: the array has no reset; a reset would turn it into DEPTH*XLEN flops
  // and would also wipe a program that must survive a core-only reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Instruction memory with a byte-stream program loader. Frame:
//   SYNC_BYTE, N (LEN_BYTES, little-endian word count), N*WB data bytes
//   (little-endian words, addresses 0..N-1), 1 checksum byte (XOR of data).
// The core is held (cpu_hold) until a frame loads and verifies.
// Ports:
//   clk           in  1       system clock, rising edge
//   rst           in  1       synchronous active-high reset
//   rx_data       in  8       host byte
//   rx_valid      in  1       rx_data valid
//   rx_ready      out 1       byte accepted when rx_valid && rx_ready
//   imem_addr     in  ADDR_W  CPU fetch word address
//   imem_rdata    out XLEN    instruction word (combinational read)
//   cpu_hold      out 1       core must hold while high
//   load_done     out 1       last frame loaded and verified
//   load_err      out 1       last frame rejected
//   words_loaded  out 16      words written by current/last frame (saturating)
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH     = 256,
  parameter int         XLEN      = 32,
  parameter int         LEN_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  localparam int        ADDR_W    = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int WB    = bytes_per_word(XLEN);
  localparam int BI_W  = byte_idx_width(WB);
  localparam int LEN_W = 8 * LEN_BYTES;
  localparam int LC_W  = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W + 1)'(DEPTH);

  state_e            r_state;
  logic              r_rx_ready;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_err;
  logic [15:0]       r_words_loaded;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_word_idx;
  logic [LC_W-1:0]   r_len_cnt;
  logic [BI_W-1:0]   r_byte_cnt;
  logic [XLEN-1:0]   r_asm;
  logic [7:0]        r_csum;

  logic              w_fire;
  logic              w_is_sync;
  logic [LEN_W-1:0]  w_len_next;
  logic              w_len_last;
  logic              w_len_bad;
  logic [XLEN-1:0]   w_word;
  logic              w_byte_last;
  logic              w_word_last;
  logic              w_we;

  assign w_fire    = rx_valid && r_rx_ready;
  assign w_is_sync = (rx_data == SYNC_BYTE);

  // Length arrives LSB first: each new byte enters at the top and the
  // register shifts down, so after LEN_BYTES bytes it holds N in order.
  if (LEN_BYTES == 1) begin : g_len1
    assign w_len_next = rx_data;
  end else begin : g_lenn
    assign w_len_next = {rx_data, r_len[LEN_W-1:8]};
  end

  assign w_len_last  = (r_len_cnt == LC_W'(LEN_BYTES - 1));
  assign w_len_bad   = (w_len_next == '0) || ({1'b0, w_len_next} > DEPTH_EXT);
  assign w_byte_last = (r_byte_cnt == BI_W'(WB - 1));
  assign w_word_last = (r_word_idx == r_len - LEN_W'(1));
  assign w_we        = w_fire && (r_state == DATA) && w_byte_last;

  // Assembly register with the incoming byte merged at its lane, so the
  // completed word can be written on the same edge as its last byte.
  // NOTE: w_word gets its default before the loop, so no latch is inferred.
  always_comb begin
    w_word = r_asm;
    for (int b = 0; b < WB; b++) begin
      if (r_byte_cnt == BI_W'(b)) w_word[b*8 +: 8] = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rx_ready     <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
      r_words_loaded <= '0;
      r_len          <= '0;
      r_word_idx     <= '0;
      r_len_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_asm          <= '0;
      r_csum         <= '0;
    end else begin
      r_rx_ready <= 1'b1;
      if (w_fire) begin
        case (r_state)
          // Sync in any resting state starts a new frame; non-sync is dropped.
          IDLE, DONE, ERR: begin
            if (w_is_sync) begin
              r_state        <= LEN;
              r_cpu_hold     <= 1'b1;
              r_load_done    <= 1'b0;
              r_load_err     <= 1'b0;
              r_words_loaded <= '0;
              r_len          <= '0;
              r_word_idx     <= '0;
              r_len_cnt      <= '0;
              r_byte_cnt     <= '0;
              r_csum         <= '0;
            end
          end
          LEN: begin
            r_len     <= w_len_next;
            r_len_cnt <= r_len_cnt + LC_W'(1);
            if (w_len_last) begin
              if (w_len_bad) begin
                r_state    <= ERR;
                r_load_err <= 1'b1;
              end else begin
                r_state <= DATA;
              end
            end
          end
          DATA: begin
            r_asm  <= w_word;
            r_csum <= r_csum ^ rx_data;
            if (w_byte_last) begin
              r_byte_cnt <= '0;
              r_word_idx <= r_word_idx + LEN_W'(1);
              if (r_words_loaded != 16'hFFFF) r_words_loaded <= r_words_loaded + 16'd1;
              if (w_word_last) r_state <= CSUM;
            end else begin
              r_byte_cnt <= r_byte_cnt + BI_W'(1);
            end
          end
          CSUM: begin
            if (rx_data == r_csum) begin
              r_state     <= DONE;
              r_load_done <= 1'b1;
              r_load_err  <= 1'b0;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_state     <= ERR;
              r_load_done <= 1'b0;
              r_load_err  <= 1'b1;
              r_cpu_hold  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_word_idx[ADDR_W-1:0]),
    .wdata (w_word),
    .raddr (imem_addr),
    .rdata (imem_rdata)
  );

  assign rx_ready     = r_rx_ready;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;

endmodule
